// File: rtl/stage_sequencer.sv
// stage_sequencer: sequences one instruction at a time through
// fetch -> decode -> exec -> [mem] -> write, with a per-stage done timeout.
// Latency: 2 cycles per stage when done follows enable by one cycle
// (10 cycles/instruction with mem, 8 without).
// Backpressure: each stage holds until its done strobe. A stage that gets
// no done within TIMEOUT_CYCLES cycles traps to ERROR, which only rst clears.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   run                   level request to keep executing instructions
//   halt_req              one-cycle pulse: stop after the current instruction retires
//   *_done                stage completion strobes
//   mem_skip              exec-stage flag: instruction has no memory access
//   *_enable              one-cycle start pulse in the first cycle of each stage
//   stage                 IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WRITE=5 ERROR=7
//   busy, error           activity / terminal error status
//   err_stage             stage code that timed out
//   retired               completed-instruction count (wraps)
module stage_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,  // legal range 2..65535
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic             fetch_done,
  input  logic             decode_done,
  input  logic             exec_done,
  input  logic             mem_done,
  input  logic             write_done,
  input  logic             mem_skip,
  output logic             fetch_enable,
  output logic             decode_enable,
  output logic             exec_enable,
  output logic             mem_enable,
  output logic             write_enable,
  output logic [2:0]       stage,
  output logic             busy,
  output logic             error,
  output logic [2:0]       err_stage,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WRITE  = 3'd5,
    S_ERROR  = 3'd7
  } state_t;

  // 16 bits covers the largest legal TIMEOUT_CYCLES.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [15:0]      wait_q;
  logic             halt_q;
  logic [4:0]       en_q;      // [0]=fetch .. [4]=write, high in first cycle of state
  logic [4:0]       en_d;
  logic [2:0]       err_q;
  logic [CNT_W-1:0] ret_q;
  logic             stage_done;
  logic             done_hit;
  logic             timeout;
  logic             entering;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    stage_done = 1'b0;
    state_d    = state_q;
    case (state_q)
      S_FETCH:  stage_done = fetch_done;
      S_DECODE: stage_done = decode_done;
      S_EXEC:   stage_done = exec_done;
      S_MEM:    stage_done = mem_done;
      S_WRITE:  stage_done = write_done;
      default:  stage_done = 1'b0;
    endcase
    // A done seen in the enable cycle cannot be a response to this enable.
    done_hit = stage_done && !(|en_q);
    timeout  = (wait_q == WAIT_LAST);

    // Done is tested before timeout so a done in the last allowed cycle wins.
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (done_hit) state_d = S_DECODE;
                else if (timeout) state_d = S_ERROR;
      S_DECODE: if (done_hit) state_d = S_EXEC;
                else if (timeout) state_d = S_ERROR;
      S_EXEC:   if (done_hit) state_d = mem_skip ? S_WRITE : S_MEM;
                else if (timeout) state_d = S_ERROR;
      S_MEM:    if (done_hit) state_d = S_WRITE;
                else if (timeout) state_d = S_ERROR;
      S_WRITE:  if (done_hit) state_d = (halt_q || halt_req || !run) ? S_IDLE : S_FETCH;
                else if (timeout) state_d = S_ERROR;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase

    // Every legal transition changes state, so a change marks a state entry.
    entering = (state_d != state_q);
    en_d[0]  = entering && (state_d == S_FETCH);
    en_d[1]  = entering && (state_d == S_DECODE);
    en_d[2]  = entering && (state_d == S_EXEC);
    en_d[3]  = entering && (state_d == S_MEM);
    en_d[4]  = entering && (state_d == S_WRITE);
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      halt_q <= 1'b0;
      en_q   <= '0;
      err_q  <= '0;
      ret_q  <= '0;
    end else begin
      en_q <= en_d;

      if (entering) begin
        wait_q <= '0;
      end else if (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WRITE}) begin
        wait_q <= wait_q + 16'd1;
      end

      if (state_d == S_IDLE) begin
        halt_q <= 1'b0;
      end else if (state_q != S_IDLE && halt_req) begin
        halt_q <= 1'b1;
      end

      if (state_q != S_ERROR && state_d == S_ERROR) begin
        err_q <= state_q;
      end

      if (state_q == S_WRITE && done_hit) begin
        ret_q <= ret_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    fetch_enable  = en_q[0];
    decode_enable = en_q[1];
    exec_enable   = en_q[2];
    mem_enable    = en_q[3];
    write_enable  = en_q[4];
    stage         = state_q;
    busy          = state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WRITE};
    error         = (state_q == S_ERROR);
    err_stage     = err_q;
    retired       = ret_q;
  end

endmodule
